// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset constants and the fetch buffer entry layout for the
// instruction fetch stage.
package inst_fetch_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic [INST_BUS-1:0]      ZERO_WORD    = '0;
    localparam logic                     RST_ENABLE   = 1'b1;
    localparam logic [INST_ADDR_BUS-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [INST_ADDR_BUS-1:0] PC_STEP      = 32'd4;

    // Credit limit shared by requests in flight and buffered instructions.
    localparam logic [2:0] MAX_CREDITS = 3'd2;

    typedef struct packed {
        logic [INST_ADDR_BUS-1:0] pc;
        logic [INST_BUS-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO used both as the issued-PC queue and the instruction buffer.
// A push and a pop in the same cycle on a full FIFO are both honoured.
module fetch_fifo2
    import inst_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage is reset too, so the head reads as zero out of reset
    // and nothing downstream ever sees X before the first write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential fetches on a req/gnt bus, pairs
// in-order responses with their PCs and presents them to IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_flag,
    input  logic [INST_ADDR_BUS-1:0] branch_target,
    output logic                     imem_req,
    output logic [INST_ADDR_BUS-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [INST_BUS-1:0]      imem_rdata,
    output logic [INST_ADDR_BUS-1:0] if_pc,
    output logic [INST_BUS-1:0]      if_inst,
    output logic                     if_valid
);

    logic [INST_ADDR_BUS-1:0] fetch_pc;
    logic [1:0]               outstanding;
    logic [1:0]               outstanding_next;
    logic [1:0]               discard;

    logic                     credit_ok;
    logic                     issue;
    logic                     resp;
    logic                     resp_keep;
    logic                     buf_pop;

    logic [INST_ADDR_BUS-1:0] pcq_head;
    logic [1:0]               pcq_count;
    fetch_entry_t             buf_push_data;
    fetch_entry_t             buf_head;
    logic [1:0]               buf_count;

    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < MAX_CREDITS;
    assign imem_req  = (rst != RST_ENABLE) && !branch_flag && credit_ok;
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    // Responses with nothing outstanding are spurious (e.g. left over from
    // before a reset) and must not touch any state.
    assign resp      = imem_rvalid && (outstanding != 2'd0);
    assign resp_keep = resp && (discard == 2'd0) && !branch_flag && (pcq_count != 2'd0);

    assign if_valid  = (buf_count != 2'd0);
    assign if_pc     = buf_head.pc;
    assign if_inst   = buf_head.inst;
    assign buf_pop   = if_valid && !stall && !branch_flag;

    assign buf_push_data = '{pc: pcq_head, inst: imem_rdata};

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        outstanding_next = outstanding;
        if (issue && !resp) begin
            outstanding_next = outstanding + 2'd1;
        end else if (!issue && resp) begin
            outstanding_next = outstanding - 2'd1;
        end
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples values from before this edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            fetch_pc    <= RESET_VECTOR;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding_next;
            if (branch_flag) begin
                // Everything still in flight after this edge belongs to the
                // abandoned path, including a response arriving right now.
                fetch_pc <= branch_target;
                discard  <= outstanding_next;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp && (discard != 2'd0)) begin
                    discard <= discard - 2'd1;
                end
            end
        end
    end

    fetch_fifo2 #(.WIDTH(INST_ADDR_BUS)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_flag),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (resp_keep),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo2 #(.WIDTH($bits(fetch_entry_t))) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_flag),
        .push      (resp_keep),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a table of per-cycle vectors from reset plus
// hand-written branch, wrap-around and reset-abandon sequences.
module tb_inst_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    logic        auto_resp;
    int          n_checks;
    int          n_pass;

    typedef struct {
        logic        do_reset;
        logic        gnt;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; the memory model answers every issue one cycle later
    // with rdata = addr ^ KEY when auto_resp is set.
    task automatic tick();
        logic        iss;
        logic [31:0] a;
        iss = imem_req && imem_gnt && !rst;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = auto_resp && iss;
        imem_rdata  = a ^ KEY;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        auto_resp     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic r, input logic g, input logic s, input logic req,
                           input logic [31:0] addr, input logic v, input logic [31:0] pc);
        vec_t e;
        e.do_reset  = r;
        e.gnt       = g;
        e.stall     = s;
        e.exp_req   = req;
        e.exp_addr  = addr;
        e.exp_valid = v;
        e.exp_pc    = pc;
        vecs.push_back(e);
    endtask

    initial begin
        logic [31:0] wrap_pcs [3];
        int          got;

        n_checks = 0;
        n_pass   = 0;

        // Reset values while rst is held.
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; auto_resp = 1'b1;
        #1;
        check("rst imem_req", {31'h0, imem_req}, 32'h0);
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst if_valid", {31'h0, if_valid}, 32'h0);
        check("rst if_pc", if_pc, 32'h0);
        check("rst if_inst", if_inst, 32'h0);

        // Streaming from reset. With two credits and a one-cycle return,
        // the buffer drains one slot every third cycle.
        add_vec(1, 1, 0, 1, 32'd0,  0, 32'd0);
        add_vec(0, 1, 0, 1, 32'd4,  0, 32'd0);
        add_vec(0, 1, 0, 0, 32'd8,  1, 32'd0);
        add_vec(0, 1, 0, 1, 32'd8,  1, 32'd4);
        add_vec(0, 1, 0, 1, 32'd12, 0, 32'd0);
        add_vec(0, 1, 0, 0, 32'd16, 1, 32'd8);
        add_vec(0, 1, 0, 1, 32'd16, 1, 32'd12);
        add_vec(0, 1, 0, 1, 32'd20, 0, 32'd0);
        // Grant withheld for three cycles: address holds at 0.
        add_vec(1, 0, 0, 1, 32'd0,  0, 32'd0);
        add_vec(0, 0, 0, 1, 32'd0,  0, 32'd0);
        add_vec(0, 0, 0, 1, 32'd0,  0, 32'd0);
        add_vec(0, 1, 0, 1, 32'd0,  0, 32'd0);
        add_vec(0, 1, 0, 1, 32'd4,  0, 32'd0);
        add_vec(0, 1, 0, 0, 32'd8,  1, 32'd0);
        add_vec(0, 1, 0, 1, 32'd8,  1, 32'd4);
        // Stall from reset: buffer fills to two, then holds for four cycles.
        add_vec(1, 1, 1, 1, 32'd0,  0, 32'd0);
        add_vec(0, 1, 1, 1, 32'd4,  0, 32'd0);
        add_vec(0, 1, 1, 0, 32'd8,  1, 32'd0);
        for (int k = 0; k < 4; k++) add_vec(0, 1, 1, 0, 32'd8, 1, 32'd0);
        add_vec(0, 1, 0, 0, 32'd8,  1, 32'd0);
        add_vec(0, 1, 0, 1, 32'd8,  1, 32'd4);
        add_vec(0, 1, 0, 1, 32'd12, 0, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) do_reset();
            imem_gnt = vecs[i].gnt;
            stall    = vecs[i].stall;
            #1;
            check($sformatf("vec%0d imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
            check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d if_inst", i), if_inst, vecs[i].exp_pc ^ KEY);
            end
            tick();
        end

        // Branch with two requests in flight, one response landing in the
        // branch cycle and one after: both dropped.
        do_reset();
        auto_resp = 1'b0;
        imem_gnt  = 1'b1;
        #1; check("br c0 addr", imem_addr, 32'h0);
        tick();
        #1; check("br c1 addr", imem_addr, 32'h4);
        tick();
        #1; check("br two inflight req", {31'h0, imem_req}, 32'h0);
        branch_flag   = 1'b1;
        branch_target = 32'h0000_1000;
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'h0 ^ KEY;
        #1; check("br cycle req", {31'h0, imem_req}, 32'h0);
        tick();
        branch_flag = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4 ^ KEY;
        #1;
        check("br after valid", {31'h0, if_valid}, 32'h0);
        check("br after req", {31'h0, imem_req}, 32'h1);
        check("br after addr", imem_addr, 32'h0000_1000);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_1000 ^ KEY;
        #1; check("br drop valid", {31'h0, if_valid}, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("br target valid", {31'h0, if_valid}, 32'h1);
        check("br target pc", if_pc, 32'h0000_1000);
        check("br target inst", if_inst, 32'h0000_1000 ^ KEY);
        tick();

        // Redirect near the top of the address space and wrap through zero.
        do_reset();
        imem_gnt      = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        #1; check("wrap branch req", {31'h0, imem_req}, 32'h0);
        tick();
        branch_flag = 1'b0;
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (if_valid) begin
                check($sformatf("wrap pc%0d", got), if_pc, wrap_pcs[got]);
                check($sformatf("wrap inst%0d", got), if_inst, wrap_pcs[got] ^ KEY);
                got++;
            end
            tick();
        end
        check("wrap count", got, 32'd3);

        // Reset with two requests in flight, then spurious responses.
        do_reset();
        auto_resp = 1'b0;
        imem_gnt  = 1'b1;
        #1; tick();
        #1; tick();
        rst = 1'b1;
        #1;
        check("midrst req", {31'h0, imem_req}, 32'h0);
        check("midrst addr", imem_addr, 32'h0);
        check("midrst valid", {31'h0, if_valid}, 32'h0);
        check("midrst pc", if_pc, 32'h0);
        check("midrst inst", if_inst, 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("spur%0d valid", c), {31'h0, if_valid}, 32'h0);
            check($sformatf("spur%0d req", c), {31'h0, imem_req}, 32'h1);
            check($sformatf("spur%0d addr", c), imem_addr, 32'h0);
            tick();
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        imem_rvalid = 1'b0;
        auto_resp   = 1'b1;
        imem_gnt    = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 1; c++) begin
            #1;
            if (if_valid) begin
                check("postrst pc", if_pc, 32'h0);
                check("postrst inst", if_inst, KEY);
                got++;
            end
            tick();
        end
        check("postrst count", got, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
